adc_sar_control: RTL and testbench
==================================

// Module: adc_sar_control
// PURPOSE
//  SAR successive-approximation controller, downstream of the clock generator with edge detect.
//  Clocked only by the generated clk_dig; one clk_dig edge = one comparator decision.
//  Drives the capacitive DAC, holds its own clock alive through ena_clkgen, and averages
//  2^osr_log2 conversions into one result with a conv_finished pulse.
// PARAMETERS
//  RESOLUTION     12  bits per single conversion (>=2)
//  SAMPLE_CYCLES  2   clk_dig cycles spent in SAMPLE per conversion (>=1)
//  MAX_OSR_LOG2   4   max averaging exponent; result width = RESOLUTION+MAX_OSR_LOG2
// PORTS
//  clk_dig        in   1              generated SAR clock, rising-edge active
//  rst_n          in   1              async active-low reset
//  start_conv     in   1              conversion request level, sampled on clk_dig
//  osr_log2       in   clog2(MAX_OSR_LOG2+1)  averaging exponent, latched at start
//  comp_p         in   1              comparator positive output (1 = input > DAC)
//  comp_n         in   1              comparator negative output, complement of comp_p
//  ena_clkgen     out  1              enable to clock generator ena_in, keeps clk_dig running
//  sample_ena     out  1              sampling switch enable (track phase)
//  dac_p          out  RESOLUTION     DAC P-side trial code
//  dac_n          out  RESOLUTION     DAC N-side code = ~dac_p
//  result         out  RESOLUTION+MAX_OSR_LOG2  accumulated sum, valid while result_valid
//  result_valid   out  1              high from DONE until next start accepted
//  conv_finished  out  1              one-cycle pulse in DONE
//  comp_err       out  1              sticky: comp_p==comp_n seen during CONV
// BEHAVIOUR
//  Reset: all outputs 0 except dac_n = all ones; state IDLE; comp_err cleared.
//  Clocking: clk_dig only toggles while edge-detect window or ena_clkgen is high; all logic
//   must tolerate an arbitrarily long gap between edges (no timeouts).
//  IDLE: ena_clkgen=0. Edge with start_conv=1 -> SAMPLE; latch osr_log2 (saturate to
//   MAX_OSR_LOG2), clear accumulator, osr_cnt=0, result_valid=0, comp_err=0.
//  SAMPLE: ena_clkgen=1, sample_ena=1, dac_p=0. After SAMPLE_CYCLES edges -> CONV with
//   bit index k=RESOLUTION-1 and dac_p = 1<<k (MSB trial).
//  CONV: ena_clkgen=1. Each edge: decide=comp_p; bit k kept if decide=1 else cleared;
//   k>0: set bit k-1 as next trial; k==0: add final code to accumulator.
//   Exactly RESOLUTION edges in CONV. comp_p==comp_n -> comp_err=1, decide=comp_p anyway.
//  After last bit: osr_cnt==2^osr_log2-1 -> DONE, else osr_cnt+1 and -> SAMPLE.
//  DONE (1 edge): result=accumulator, result_valid=1, conv_finished=1, ena_clkgen=0,
//   dac_p=0 -> IDLE. conv_finished low on every other edge.
//  Latency (osr_log2=0): SAMPLE_CYCLES+RESOLUTION+1 clk_dig edges from accepted start.
//  Accumulator: unsigned, width RESOLUTION+MAX_OSR_LOG2, cannot overflow; no right shift.
//  start_conv high while not IDLE: ignored; still high on DONE->IDLE edge is a new request
//   only after one edge in IDLE (no back-to-back restart without IDLE).
//  rst_n asserted mid-operation: immediate return to reset values; clkgen stops via ena_clkgen.
//  dac_n always the bitwise complement of dac_p, same register stage (no skew cycle).
// STRUCTURE
//  Shared package adc_sar_pkg: state enum (IDLE,SAMPLE,CONV,DONE), default RESOLUTION,
//   MAX_OSR_LOG2 constants, result width function.
//  One sub-module: adc_sar_bitreg (SAR register + bit pointer: load MSB trial, shift on
//   decision, last_bit flag). FSM, counters, accumulator stay in top.
// TESTING
//  1 Reset: rst_n=0 -> ena_clkgen=0, dac_p=0, dac_n=12'hFFF, result=0, comp_err=0.
//  2 Single conv, osr_log2=0, comparator model vin=12'hA5C -> result=16'h0A5C after
//    2+12+1 edges, conv_finished 1 cycle, ena_clkgen low in DONE.
//  3 osr_log2=2, vin alternating 12'h400/12'h401 -> result=16'h1002, 4 SAMPLE phases seen.
//  4 Extremes: vin=0 -> 16'h0000; vin=12'hFFF -> 16'h0FFF; MSB trial dac_p=12'h800 first.
//  5 comp_p=comp_n=1 on 3rd CONV edge -> comp_err=1 sticky until next start, code still done.
//  6 rst_n pulse at CONV bit 5 -> outputs reset instantly; new start completes correctly;
//    start_conv held high through DONE -> no restart until one IDLE edge.

Source files
------------

// File: rtl/adc_sar_pkg.sv
// Shared types and defaults for the SAR ADC controller slice.
package adc_sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONV,
    DONE
  } sar_state_t;

  localparam int SAR_RESOLUTION    = 12;
  localparam int SAR_SAMPLE_CYCLES = 2;
  localparam int SAR_MAX_OSR_LOG2  = 4;

  function automatic int sar_result_w(input int resolution, input int max_osr_log2);
    return resolution + max_osr_log2;
  endfunction

endpackage

// File: rtl/adc_sar_control_if.sv
// Host-side request/result bundle of the SAR controller.
interface adc_sar_control_if
  import adc_sar_pkg::*;
#(
  parameter int RESOLUTION   = SAR_RESOLUTION,
  parameter int MAX_OSR_LOG2 = SAR_MAX_OSR_LOG2
);
  localparam int RESULT_W = sar_result_w(RESOLUTION, MAX_OSR_LOG2);
  localparam int OSR_W    = $clog2(MAX_OSR_LOG2 + 1);

  logic                start_conv;
  logic [OSR_W-1:0]    osr_log2;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic                conv_finished;

  modport master (
    output start_conv, osr_log2,
    input  result, result_valid, conv_finished
  );

  modport slave (
    input  start_conv, osr_log2,
    output result, result_valid, conv_finished
  );
endinterface

// File: rtl/adc_sar_bitreg.sv
// SAR trial register with bit pointer: MSB load, one decision per step.
module adc_sar_bitreg
  import adc_sar_pkg::*;
#(
  parameter int RESOLUTION = SAR_RESOLUTION
) (
  input  logic                  clk_dig,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  decide,
  output logic [RESOLUTION-1:0] code,
  output logic [RESOLUTION-1:0] decided_code,
  output logic                  last_bit
);
  localparam int KW = $clog2(RESOLUTION);

  logic [KW-1:0]         k;
  logic [RESOLUTION-1:0] trial;

  always_comb begin
    decided_code    = code;
    decided_code[k] = decide;
    trial           = '0;
    if (k != '0) trial[k - KW'(1)] = 1'b1;
  end

  assign last_bit = (k == '0);

  // After the last decision the DAC code parks at zero for DONE/SAMPLE.
  always_ff @(posedge clk_dig or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      k    <= '0;
    end else if (load) begin
      code <= {1'b1, {(RESOLUTION-1){1'b0}}};
      k    <= KW'(RESOLUTION - 1);
    end else if (step) begin
      code <= last_bit ? '0 : (decided_code | trial);
      if (!last_bit) k <= k - KW'(1);
    end
  end
endmodule

// File: rtl/adc_sar_control.sv
// SAR conversion sequencer: sample, binary search, oversampling accumulation.
module adc_sar_control
  import adc_sar_pkg::*;
#(
  parameter int RESOLUTION    = SAR_RESOLUTION,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int MAX_OSR_LOG2  = SAR_MAX_OSR_LOG2
) (
  input  logic                  clk_dig,
  input  logic                  rst_n,
  adc_sar_control_if.slave      host,
  input  logic                  comp_p,
  input  logic                  comp_n,
  output logic                  ena_clkgen,
  output logic                  sample_ena,
  output logic [RESOLUTION-1:0] dac_p,
  output logic [RESOLUTION-1:0] dac_n,
  output logic                  comp_err
);
  localparam int RESULT_W = sar_result_w(RESOLUTION, MAX_OSR_LOG2);
  localparam int OSR_W    = $clog2(MAX_OSR_LOG2 + 1);
  localparam int SW       = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int CW       = (MAX_OSR_LOG2 > 0) ? MAX_OSR_LOG2 : 1;

  function automatic logic [OSR_W-1:0] sat_osr(input logic [OSR_W-1:0] v);
    if (v > OSR_W'(MAX_OSR_LOG2)) return OSR_W'(MAX_OSR_LOG2);
    return v;
  endfunction

  sar_state_t            state, state_nxt;
  logic [SW-1:0]         samp_cnt;
  logic [OSR_W-1:0]      osr_lat;
  logic [CW-1:0]         osr_cnt;
  logic [CW:0]           osr_tgt;
  logic [RESULT_W-1:0]   acc, acc_sum, result_q;
  logic                  result_valid_q;
  logic                  samp_last, osr_last, start_acc;
  logic                  load, step, last_bit;
  logic [RESOLUTION-1:0] code, decided_code;

  adc_sar_bitreg #(.RESOLUTION(RESOLUTION)) u_bitreg (
    .clk_dig      (clk_dig),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .decide       (comp_p),
    .code         (code),
    .decided_code (decided_code),
    .last_bit     (last_bit)
  );

  assign samp_last = (samp_cnt == SW'(SAMPLE_CYCLES - 1));
  assign osr_tgt   = ({{CW{1'b0}}, 1'b1} << osr_lat) - (CW+1)'(1);
  assign osr_last  = ({1'b0, osr_cnt} == osr_tgt);
  assign start_acc = (state == IDLE) && host.start_conv;
  assign acc_sum   = acc + RESULT_W'(decided_code);

  always_ff @(posedge clk_dig or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (host.start_conv) state_nxt = SAMPLE;
      SAMPLE: if (samp_last) state_nxt = CONV;
      CONV:   if (last_bit) state_nxt = osr_last ? DONE : SAMPLE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ena_clkgen         = 1'b0;
    sample_ena         = 1'b0;
    host.conv_finished = 1'b0;
    load               = 1'b0;
    step               = 1'b0;
    unique case (state)
      SAMPLE: begin
        ena_clkgen = 1'b1;
        sample_ena = 1'b1;
        load       = samp_last;
      end
      CONV: begin
        ena_clkgen = 1'b1;
        step       = 1'b1;
      end
      DONE:    host.conv_finished = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_dig or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt       <= '0;
      osr_lat        <= '0;
      osr_cnt        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      comp_err       <= 1'b0;
    end else if (start_acc) begin
      samp_cnt       <= '0;
      osr_lat        <= sat_osr(host.osr_log2);
      osr_cnt        <= '0;
      result_valid_q <= 1'b0;
      comp_err       <= 1'b0;
    end else if (state == SAMPLE) begin
      samp_cnt <= samp_last ? '0 : samp_cnt + SW'(1);
    end else if (state == CONV) begin
      // A non-complementary comparator pair is flagged but the decision still follows comp_p.
      if (comp_p == comp_n) comp_err <= 1'b1;
      if (last_bit) begin
        if (osr_last) begin
          result_q       <= acc_sum;
          result_valid_q <= 1'b1;
        end else begin
          osr_cnt <= osr_cnt + CW'(1);
        end
      end
    end
  end

  // Datapath accumulator: cleared on every accepted start, so no reset needed.
  always_ff @(posedge clk_dig) begin
    if (start_acc)                        acc <= '0;
    else if ((state == CONV) && last_bit) acc <= acc_sum;
  end

  assign host.result       = result_q;
  assign host.result_valid = result_valid_q;
  assign dac_p             = code;
  assign dac_n             = ~code;
endmodule

// File: tb/tb_adc_sar_control.sv
// Self-checking bench for adc_sar_control with a behavioural comparator model.
module tb_adc_sar_control;
  localparam int RES = 12;
  localparam int SC  = 2;
  localparam int MOL = 4;
  localparam int RW  = RES + MOL;
  localparam int OW  = $clog2(MOL + 1);

  logic           clk_dig = 1'b0;
  logic           rst_n   = 1'b0;
  logic           comp_p, comp_n;
  logic           ena_clkgen, sample_ena, comp_err;
  logic [RES-1:0] dac_p, dac_n;

  always #5 clk_dig = ~clk_dig;

  adc_sar_control_if #(.RESOLUTION(RES), .MAX_OSR_LOG2(MOL)) host ();

  adc_sar_control #(.RESOLUTION(RES), .SAMPLE_CYCLES(SC), .MAX_OSR_LOG2(MOL)) dut (
    .clk_dig    (clk_dig),
    .rst_n      (rst_n),
    .host       (host),
    .comp_p     (comp_p),
    .comp_n     (comp_n),
    .ena_clkgen (ena_clkgen),
    .sample_ena (sample_ena),
    .dac_p      (dac_p),
    .dac_n      (dac_n),
    .comp_err   (comp_err)
  );

  // Comparator model: odd-numbered sample phases see vin0, even ones vin1.
  logic [RES-1:0] vin0 = '0, vin1 = '0, vin;
  logic           force_eq = 1'b0;
  int             phase_cnt = 0, phase_base = 0, edge_cnt = 0, mark = 0;

  always @(posedge sample_ena) phase_cnt <= phase_cnt + 1;
  always @(posedge clk_dig) edge_cnt <= edge_cnt + 1;

  assign vin    = (((phase_cnt - phase_base) % 2) != 0) ? vin0 : vin1;
  assign comp_p = force_eq ? 1'b1 : (vin >= dac_p);
  assign comp_n = force_eq ? 1'b1 : (vin < dac_p);

  int checks = 0, errors = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [RES-1:0] v0;
    logic [RES-1:0] v1;
    logic [OW-1:0]  osr;
    logic [RW-1:0]  exp_res;
    int             phases;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic kick(input logic [OW-1:0] osr, input logic [RW-1:0] exp_res);
    @(negedge clk_dig);
    host.osr_log2   = osr;
    host.start_conv = 1'b1;
    mark            = edge_cnt;
    phase_base      = phase_cnt;
    exp_q.push_back(exp_res);
    @(negedge clk_dig);
    host.start_conv = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_phases);
    bit            seen;
    logic [RW-1:0] exp_res;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (host.conv_finished) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_dig);
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (seen) begin
      chk({name, "_result"}, 32'(host.result), 32'(exp_res));
      chk({name, "_valid"}, 32'(host.result_valid), 32'd1);
      chk({name, "_clkgen_off"}, 32'(ena_clkgen), 32'd0);
      chk({name, "_dac_park"}, 32'(dac_p), 32'd0);
      chk({name, "_latency"}, 32'(edge_cnt - mark), 32'(1 + exp_phases * (SC + RES)));
      chk({name, "_phases"}, 32'(phase_cnt - phase_base), 32'(exp_phases));
      @(negedge clk_dig);
      chk({name, "_pulse_end"}, 32'(host.conv_finished), 32'd0);
      chk({name, "_valid_hold"}, 32'(host.result_valid), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    host.start_conv = 1'b0;
    host.osr_log2   = '0;
    vecs[0] = '{12'hA5C, 12'hA5C, 3'd0, 16'h0A5C, 1};
    vecs[1] = '{12'h400, 12'h401, 3'd2, 16'h1002, 4};
    vecs[2] = '{12'h000, 12'h000, 3'd0, 16'h0000, 1};
    vecs[3] = '{12'hFFF, 12'hFFF, 3'd0, 16'h0FFF, 1};
    vecs[4] = '{12'h123, 12'h456, 3'd1, 16'h0579, 2};
    vecs[5] = '{12'hFFF, 12'hFFF, 3'd7, 16'hFFF0, 16};
    vecs[6] = '{12'h801, 12'h7FE, 3'd3, 16'h3FFC, 8};

    // Reset state
    #12;
    chk("rst_clkgen", 32'(ena_clkgen), 32'd0);
    chk("rst_sample", 32'(sample_ena), 32'd0);
    chk("rst_dac_p", 32'(dac_p), 32'd0);
    chk("rst_dac_n", 32'(dac_n), 32'hFFF);
    chk("rst_result", 32'(host.result), 32'd0);
    chk("rst_valid", 32'(host.result_valid), 32'd0);
    chk("rst_finished", 32'(host.conv_finished), 32'd0);
    chk("rst_comp_err", 32'(comp_err), 32'd0);
    @(negedge clk_dig);
    rst_n = 1'b1;

    // MSB trial and sampling phase, then completion
    vin0 = 12'hA5C; vin1 = 12'hA5C;
    kick(3'd0, 16'h0A5C);
    chk("samp_ena", 32'(sample_ena), 32'd1);
    chk("samp_clkgen", 32'(ena_clkgen), 32'd1);
    chk("samp_dac", 32'(dac_p), 32'd0);
    chk("valid_cleared", 32'(host.result_valid), 32'd0);
    @(negedge clk_dig);
    @(negedge clk_dig);
    chk("msb_trial", 32'(dac_p), 32'h800);
    chk("msb_trial_n", 32'(dac_n), 32'h7FF);
    chk("conv_no_sample", 32'(sample_ena), 32'd0);
    wait_done("first", 1);

    // Table-driven vectors
    for (int v = 0; v < 7; v++) begin
      vin0 = vecs[v].v0;
      vin1 = vecs[v].v1;
      kick(vecs[v].osr, vecs[v].exp_res);
      wait_done($sformatf("vec%0d", v), vecs[v].phases);
      chk($sformatf("vec%0d_comp_err", v), 32'(comp_err), 32'd0);
    end

    // Comparator fault on the third CONV edge
    vin0 = 12'hA5C; vin1 = 12'hA5C;
    kick(3'd0, 16'h0A5C);
    repeat (4) @(negedge clk_dig);
    force_eq = 1'b1;
    @(negedge clk_dig);
    force_eq = 1'b0;
    chk("comp_err_set", 32'(comp_err), 32'd1);
    wait_done("comp_err_conv", 1);
    chk("comp_err_sticky", 32'(comp_err), 32'd1);
    vin0 = 12'h3C3; vin1 = 12'h3C3;
    kick(3'd0, 16'h03C3);
    chk("comp_err_cleared", 32'(comp_err), 32'd0);
    wait_done("after_err", 1);

    // Asynchronous reset in the middle of CONV bit 5
    vin0 = 12'h5A5; vin1 = 12'h5A5;
    kick(3'd0, 16'h05A5);
    repeat (8) @(negedge clk_dig);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_clkgen", 32'(ena_clkgen), 32'd0);
    chk("mid_rst_dac_p", 32'(dac_p), 32'd0);
    chk("mid_rst_dac_n", 32'(dac_n), 32'hFFF);
    chk("mid_rst_result", 32'(host.result), 32'd0);
    chk("mid_rst_valid", 32'(host.result_valid), 32'd0);
    @(negedge clk_dig);
    rst_n = 1'b1;
    kick(3'd0, 16'h05A5);
    wait_done("post_rst", 1);

    // start_conv held high through DONE needs one IDLE edge before restarting
    vin0 = 12'h3C3; vin1 = 12'h3C3;
    kick(3'd0, 16'h03C3);
    host.start_conv = 1'b1;
    wait_done("held", 1);
    chk("held_idle_gap", 32'(sample_ena), 32'd0);
    chk("held_idle_clkgen", 32'(ena_clkgen), 32'd0);
    mark       = edge_cnt;
    phase_base = phase_cnt;
    exp_q.push_back(16'h03C3);
    @(negedge clk_dig);
    chk("held_restart", 32'(sample_ena), 32'd1);
    host.start_conv = 1'b0;
    wait_done("restart", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
